pwm_bank_avmm: RTL and testbench
================================

Name: pwm_bank_avmm

Overview:
Parametrised multi-channel PWM generator with an Avalon-MM slave register port. It replaces the fixed 8-channel PWM outputs in soc_system and is driven by the HPS over the lightweight bridge. Each channel has its own period and duty registers. New values are double-buffered and take effect only at period wrap, so updates are glitch-free. Adds a shared prescaler, per-channel polarity, wrap-status flags and a level interrupt.

Parameters:
NUM_CH, 8, number of PWM channels (1..16)
CNT_W, 16, width of period/duty counters (8..32)
PRESC_W, 16, width of shared prescaler
ADDR_W, 5, word-address width; must satisfy 2^ADDR_W >= 8+2*NUM_CH

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
s1_address  in  ADDR_W  word address
s1_chipselect  in  1  slave select
s1_write_n  in  1  active-low write strobe
s1_writedata  in  32  write data
s1_read_n  in  1  active-low read strobe
s1_readdata  out  32  read data, 1-cycle latency
pwm_out  out  NUM_CH  PWM outputs
irq  out  1  level interrupt, active high

Behaviour:
- Register map (word offsets):
  - 0 ENABLE[NUM_CH-1:0]
  - 1 POLARITY[NUM_CH-1:0]
  - 2 PRESCALE[PRESC_W-1:0]
  - 3 IRQ_EN[NUM_CH-1:0]
  - 4 STATUS[NUM_CH-1:0], write-1-to-clear
  - 8+2c PERIOD_c[CNT_W-1:0]
  - 9+2c DUTY_c[CNT_W-1:0]
- Unmapped reads return 0. Unmapped writes are ignored. Bits above the field width read 0.
- Write takes effect when chipselect=1 and write_n=0 on the rising edge.
- Read: readdata is registered on the edge where chipselect=1 and read_n=0, and is valid the following cycle. It holds its value otherwise.
- Reset: all registers 0, all counters 0, s1_readdata=0, pwm_out=0, irq=0.
- Prescaler:
  - presc_cnt counts 0..PRESCALE and wraps to 0.
  - tick=1 for one clk when presc_cnt==PRESCALE, so PRESCALE=0 gives tick every cycle.
  - A PRESCALE write restarts presc_cnt at 0.
  - The prescaler is free-running regardless of ENABLE.
- Channel c enabled (ENABLE[c]=1):
  - On tick, cnt_c increments.
  - If cnt_c==per_sh_c at the tick, cnt_c wraps to 0, per_sh_c<=PERIOD_c, duty_sh_c<=DUTY_c, and STATUS[c] is set.
  - Period is PERIOD+1 ticks.
- pwm_out[c] is registered and equals (cnt_c < duty_sh_c) XOR POLARITY[c].
  - Output is one clk behind the counter.
  - DUTY=0 gives a constant inactive level.
  - DUTY>PERIOD gives a constant active level.
- ENABLE[c] 0->1: cnt_c=0 and shadows load from PERIOD_c/DUTY_c on the same edge, with no wait for wrap.
- ENABLE[c]=0: cnt_c is held at 0, shadows are frozen, and pwm_out[c]=POLARITY[c] (inactive level).
- PERIOD/DUTY writes while running affect only the live registers; the output changes only after the next wrap.
- STATUS set and W1C in the same cycle on the same bit: set wins.
- irq = |(STATUS & IRQ_EN), registered.
- Reset asserted mid-period: everything returns to reset values immediately (asynchronous), and outputs go to 0.

Decomposition:
- Package pwm_bank_pkg holds:
  - register offset constants (REG_ENABLE=0, REG_POLARITY=1, REG_PRESCALE=2, REG_IRQ_EN=3, REG_STATUS=4, REG_CH_BASE=8)
  - a function ch_reg_addr(c, is_duty)
- Sub-module pwm_channel, instantiated NUM_CH times via generate. It contains:
  - the counter and shadow registers
  - the compare
  - polarity
  - the wrap pulse output
- Top level holds the register file, prescaler, readback mux and irq.

Test Plan:
- Reset, then read all offsets 0..31 -> all 0; pwm_out=0; irq=0.
- PRESCALE=0, PERIOD_0=9, DUTY_0=3, ENABLE=1 -> pwm_out[0] high 3 clk, low 7 clk, repeating every 10 clk; STATUS[0] set once per 10 clk.
- Channel 0 running as above, write DUTY_0=7 mid-period -> current period keeps a 3-clk high; next period starts with a 7-clk high exactly at wrap.
- PRESCALE=4, PERIOD_1=1, DUTY_1=1, POLARITY[1]=1, ENABLE=2 -> pwm_out[1] low 5 clk, high 5 clk; disable -> pwm_out[1]=1 constant.
- DUTY_2=0 -> constant 0; DUTY_2=PERIOD_2+1=6 -> constant 1; no glitch at wrap.
- IRQ_EN=1, wait for wrap -> irq=1; W1C STATUS=1 on a cycle coinciding with the next wrap -> STATUS[0] stays 1; assert reset_reset_n=0 mid-period -> pwm_out=0 and irq=0 asynchronously.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared register map for the PWM bank: fixed control offsets and the
// per-channel PERIOD/DUTY word layout starting at REG_CH_BASE.
package pwm_bank_pkg;

   localparam int REG_ENABLE   = 0;
   localparam int REG_POLARITY = 1;
   localparam int REG_PRESCALE = 2;
   localparam int REG_IRQ_EN   = 3;
   localparam int REG_STATUS   = 4;
   localparam int REG_CH_BASE  = 8;

   // Each channel owns two consecutive words: PERIOD then DUTY.
   function automatic int ch_reg_addr(input int c, input logic is_duty);
      return REG_CH_BASE + 2 * c + (is_duty ? 1 : 0);
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: tick-driven counter, period/duty shadows reloaded at wrap,
// registered compare output with polarity and a combinational wrap pulse.
module pwm_channel #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             enable,
   input  logic             load,
   input  logic             polarity,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] duty,
   output logic             pwm,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] per_sh;
   logic [CNT_W-1:0] duty_sh;

   assign wrap = enable && tick && (cnt == per_sh);

   // load fires on the edge that turns the channel on, so it starts a fresh
   // period from the live registers instead of waiting for a wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         per_sh  <= '0;
         duty_sh <= '0;
      end else if (load || wrap) begin
         cnt     <= '0;
         per_sh  <= period;
         duty_sh <= duty;
      end else if (!enable) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm <= 1'b0;
      end else if (enable) begin
         pwm <= (cnt < duty_sh) ^ polarity;
      end else begin
         pwm <= polarity;
      end
   end

endmodule

// File: rtl/pwm_bank_avmm.sv
// Multi-channel PWM bank with an Avalon-MM register port: register file,
// shared prescaler, readback mux, wrap status and level interrupt.
module pwm_bank_avmm
   import pwm_bank_pkg::*;
#(
   parameter int NUM_CH  = 8,
   parameter int CNT_W   = 16,
   parameter int PRESC_W = 16,
   parameter int ADDR_W  = 5
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [ADDR_W-1:0] s1_address,
   input  logic              s1_chipselect,
   input  logic              s1_write_n,
   input  logic [31:0]       s1_writedata,
   input  logic              s1_read_n,
   output logic [31:0]       s1_readdata,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              irq
);

   logic [NUM_CH-1:0]  enable_reg;
   logic [NUM_CH-1:0]  polarity_reg;
   logic [PRESC_W-1:0] prescale_reg;
   logic [NUM_CH-1:0]  irq_en_reg;
   logic [NUM_CH-1:0]  status_reg;
   logic [CNT_W-1:0]   period_reg [NUM_CH];
   logic [CNT_W-1:0]   duty_reg   [NUM_CH];

   logic [PRESC_W-1:0] presc_cnt;
   logic               tick;
   logic               wr;
   logic               rd;
   logic [31:0]        addr_w;
   logic [31:0]        rd_mux;
   logic [NUM_CH-1:0]  en_load;
   logic [NUM_CH-1:0]  status_clr;
   logic [NUM_CH-1:0]  wrap_vec;
   logic               unused_wdata;

   assign wr           = s1_chipselect && !s1_write_n;
   assign rd           = s1_chipselect && !s1_read_n;
   assign addr_w       = 32'(s1_address);
   assign tick         = (presc_cnt == prescale_reg);
   assign unused_wdata = ^s1_writedata;

   assign en_load    = (wr && addr_w == REG_ENABLE) ? (s1_writedata[NUM_CH-1:0] & ~enable_reg) : '0;
   assign status_clr = (wr && addr_w == REG_STATUS) ? s1_writedata[NUM_CH-1:0] : '0;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         enable_reg   <= '0;
         polarity_reg <= '0;
         prescale_reg <= '0;
         irq_en_reg   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            period_reg[c] <= '0;
            duty_reg[c]   <= '0;
         end
      end else if (wr) begin
         if (addr_w == REG_ENABLE)   enable_reg   <= s1_writedata[NUM_CH-1:0];
         if (addr_w == REG_POLARITY) polarity_reg <= s1_writedata[NUM_CH-1:0];
         if (addr_w == REG_PRESCALE) prescale_reg <= s1_writedata[PRESC_W-1:0];
         if (addr_w == REG_IRQ_EN)   irq_en_reg   <= s1_writedata[NUM_CH-1:0];
         for (int c = 0; c < NUM_CH; c++) begin
            if (addr_w == ch_reg_addr(c, 1'b0)) period_reg[c] <= s1_writedata[CNT_W-1:0];
            if (addr_w == ch_reg_addr(c, 1'b1)) duty_reg[c]   <= s1_writedata[CNT_W-1:0];
         end
      end
   end

   // A wrap landing on the same edge as a write-1-to-clear keeps the bit set.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         status_reg <= '0;
         irq        <= 1'b0;
      end else begin
         status_reg <= (status_reg & ~status_clr) | wrap_vec;
         irq        <= |(status_reg & irq_en_reg);
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         presc_cnt <= '0;
      end else if ((wr && addr_w == REG_PRESCALE) || tick) begin
         presc_cnt <= '0;
      end else begin
         presc_cnt <= presc_cnt + PRESC_W'(1);
      end
   end

   always_comb begin
      rd_mux = '0;
      if (addr_w == REG_ENABLE)   rd_mux = 32'(enable_reg);
      if (addr_w == REG_POLARITY) rd_mux = 32'(polarity_reg);
      if (addr_w == REG_PRESCALE) rd_mux = 32'(prescale_reg);
      if (addr_w == REG_IRQ_EN)   rd_mux = 32'(irq_en_reg);
      if (addr_w == REG_STATUS)   rd_mux = 32'(status_reg);
      for (int c = 0; c < NUM_CH; c++) begin
         if (addr_w == ch_reg_addr(c, 1'b0)) rd_mux = 32'(period_reg[c]);
         if (addr_w == ch_reg_addr(c, 1'b1)) rd_mux = 32'(duty_reg[c]);
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         s1_readdata <= '0;
      end else if (rd) begin
         s1_readdata <= rd_mux;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      pwm_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk     (clk_clk),
         .rst_n   (reset_reset_n),
         .tick    (tick),
         .enable  (enable_reg[c]),
         .load    (en_load[c]),
         .polarity(polarity_reg[c]),
         .period  (period_reg[c]),
         .duty    (duty_reg[c]),
         .pwm     (pwm_out[c]),
         .wrap    (wrap_vec[c])
      );
   end

endmodule

// File: tb/tb_pwm_bank_avmm.sv
// Scoreboard bench for pwm_bank_avmm: expected read data and per-cycle PWM
// levels are queued as stimulus is driven and popped when the DUT answers.
module tb_pwm_bank_avmm;

   localparam int NUM_CH  = 8;
   localparam int CNT_W   = 16;
   localparam int PRESC_W = 16;
   localparam int ADDR_W  = 5;

   localparam int REG_ENABLE   = 0;
   localparam int REG_POLARITY = 1;
   localparam int REG_PRESCALE = 2;
   localparam int REG_IRQ_EN   = 3;
   localparam int REG_STATUS   = 4;

   logic              clk_clk;
   logic              reset_reset_n;
   logic [ADDR_W-1:0] s1_address;
   logic              s1_chipselect;
   logic              s1_write_n;
   logic [31:0]       s1_writedata;
   logic              s1_read_n;
   logic [31:0]       s1_readdata;
   logic [NUM_CH-1:0] pwm_out;
   logic              irq;

   int          check_count = 0;
   int          error_count = 0;
   logic [31:0] exp_q[$];

   pwm_bank_avmm #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .PRESC_W(PRESC_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .s1_address   (s1_address),
      .s1_chipselect(s1_chipselect),
      .s1_write_n   (s1_write_n),
      .s1_writedata (s1_writedata),
      .s1_read_n    (s1_read_n),
      .s1_readdata  (s1_readdata),
      .pwm_out      (pwm_out),
      .irq          (irq)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic [31:0] got);
      logic [31:0] exp;
      if (exp_q.size() == 0) begin
         check_count++;
         error_count++;
         $display("[TB] FAIL %s: scoreboard empty, got 0x%08h", tag, got);
      end else begin
         exp = exp_q.pop_front();
         check_output(tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   // Bus tasks start at a negedge, consume exactly one rising edge and
   // return at the following negedge.
   task automatic write_reg(input int addr, input logic [31:0] data);
      s1_address    = ADDR_W'(addr);
      s1_writedata  = data;
      s1_chipselect = 1'b1;
      s1_write_n    = 1'b0;
      @(posedge clk_clk);
      @(negedge clk_clk);
      s1_chipselect = 1'b0;
      s1_write_n    = 1'b1;
   endtask

   task automatic read_reg(input string tag, input int addr, input logic [31:0] exp, input logic [31:0] mask);
      s1_address    = ADDR_W'(addr);
      s1_chipselect = 1'b1;
      s1_read_n     = 1'b0;
      exp_q.push_back(exp);
      @(posedge clk_clk);
      @(negedge clk_clk);
      s1_chipselect = 1'b0;
      s1_read_n     = 1'b1;
      pop_check(tag, s1_readdata & mask);
   endtask

   task automatic expect_pwm(input string tag, input logic [31:0] exp);
      exp_q.push_back(exp);
      @(negedge clk_clk);
      pop_check(tag, 32'(pwm_out));
   endtask

   initial begin
      int j;
      int c1;
      reset_reset_n = 1'b0;
      s1_address    = '0;
      s1_chipselect = 1'b0;
      s1_write_n    = 1'b1;
      s1_writedata  = '0;
      s1_read_n     = 1'b1;

      wait_cycles(3);
      check_output("reset_pwm", 32'(pwm_out), 32'h0);
      check_output("reset_irq", 32'(irq), 32'h0);
      check_output("reset_rdata", s1_readdata, 32'h0);
      reset_reset_n = 1'b1;
      wait_cycles(1);

      for (int a = 0; a < 32; a++)
         read_reg($sformatf("reset_read_%0d", a), a, 32'h0, 32'hFFFF_FFFF);

      // Channel 0: 10-clk period, 3-clk high.
      write_reg(REG_PRESCALE, 32'd0);
      write_reg(8, 32'd9);
      write_reg(9, 32'd3);
      write_reg(REG_ENABLE, 32'h1);
      check_output("ch0_enable_edge", 32'(pwm_out), 32'h0);
      for (int i = 0; i < 30; i++)
         expect_pwm("ch0_wave", ((i % 10) < 3) ? 32'h1 : 32'h0);
      read_reg("status_after_wraps", REG_STATUS, 32'h1, 32'hFFFF_FFFF);

      // Duty change mid-period only takes effect from the wrap at edge 40.
      write_reg(9, 32'd7);
      for (int k = 33; k <= 60; k++)
         expect_pwm("ch0_duty_update", (((k - 1) % 10) < (((k - 1) >= 40) ? 7 : 3)) ? 32'h1 : 32'h0);

      // Channel 1 inverted with prescale 4: ticks land on edges 69, 74, ...
      write_reg(10, 32'd1);
      write_reg(11, 32'd1);
      write_reg(REG_POLARITY, 32'h2);
      write_reg(REG_PRESCALE, 32'd4);
      write_reg(REG_ENABLE, 32'h2);
      for (int k = 66; k <= 89; k++) begin
         j  = k - 1;
         c1 = (j < 69) ? 0 : ((((j - 69) / 5) + 1) % 2);
         expect_pwm("ch1_presc_wave", 32'(c1) << 1);
      end
      write_reg(REG_ENABLE, 32'h0);
      for (int i = 0; i < 10; i++)
         expect_pwm("ch1_disabled", 32'h2);

      // Channel 2: duty 0 is flat low, duty > period is flat high after wrap.
      write_reg(REG_PRESCALE, 32'd0);
      write_reg(REG_POLARITY, 32'h0);
      write_reg(12, 32'd5);
      write_reg(13, 32'd0);
      write_reg(REG_ENABLE, 32'h4);
      for (int i = 1; i <= 20; i++)
         expect_pwm("ch2_duty0", 32'h0);
      write_reg(13, 32'd6);
      for (int m = 22; m <= 40; m++)
         expect_pwm("ch2_duty_full", ((m - 1) >= 24) ? 32'h4 : 32'h0);

      // Interrupt, W1C colliding with a wrap, then asynchronous reset.
      write_reg(REG_STATUS, 32'hFF);
      write_reg(REG_IRQ_EN, 32'h1);
      write_reg(REG_ENABLE, 32'h1);
      wait_cycles(10);
      check_output("irq_before_wrap", 32'(irq), 32'h0);
      wait_cycles(1);
      check_output("irq_after_wrap", 32'(irq), 32'h1);
      wait_cycles(8);
      write_reg(REG_STATUS, 32'h1);
      read_reg("status_set_wins", REG_STATUS, 32'h1, 32'h1);
      check_output("irq_held", 32'(irq), 32'h1);
      write_reg(REG_STATUS, 32'h1);
      read_reg("status_w1c", REG_STATUS, 32'h0, 32'h1);
      check_output("irq_cleared", 32'(irq), 32'h0);
      wait_cycles(9);
      check_output("pre_reset_pwm", 32'(pwm_out), 32'h1);
      check_output("pre_reset_irq", 32'(irq), 32'h1);
      #2;
      reset_reset_n = 1'b0;
      #1;
      check_output("async_reset_pwm", 32'(pwm_out), 32'h0);
      check_output("async_reset_irq", 32'(irq), 32'h0);
      check_output("async_reset_rdata", s1_readdata, 32'h0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      wait_cycles(1);
      read_reg("post_reset_enable", REG_ENABLE, 32'h0, 32'hFFFF_FFFF);
      read_reg("post_reset_period0", 8, 32'h0, 32'hFFFF_FFFF);
      read_reg("post_reset_status", REG_STATUS, 32'h0, 32'hFFFF_FFFF);
      check_output("post_reset_pwm", 32'(pwm_out), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
